// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: ALU opcodes, instruction fields, FSM states and opcode helpers
package alu_issue_ctrl_pkg;
  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int OP_HI = 15;
  localparam int OP_LO = 11;
  localparam int RD_HI = 10;
  localparam int RD_LO = 8;
  localparam int RS_HI = 7;
  localparam int RS_LO = 5;
  localparam int RT_HI = 4;
  localparam int RT_LO = 2;
  localparam int COE_BIT = 1;
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_ADDU = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_SUBU = 5'b00011;
  localparam logic [4:0] OP_INC  = 5'b00100;
  localparam logic [4:0] OP_DEC  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b01000;
  localparam logic [4:0] OP_OR   = 5'b01001;
  localparam logic [4:0] OP_XOR  = 5'b01010;
  localparam logic [4:0] OP_NOT  = 5'b01100;
  localparam logic [4:0] OP_SLL  = 5'b10000;
  localparam logic [4:0] OP_SRL  = 5'b10001;
  localparam logic [4:0] OP_SLA  = 5'b10010;
  localparam logic [4:0] OP_SRA  = 5'b10011;
  localparam logic [4:0] OP_SLT  = 5'b11000;
  localparam logic [4:0] OP_SLE  = 5'b11001;
  localparam logic [4:0] OP_SGT  = 5'b11010;
  localparam logic [4:0] OP_SGE  = 5'b11011;
  localparam logic [4:0] OP_SEQ  = 5'b11100;
  localparam logic [4:0] OP_SNE  = 5'b11101;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB, ST_ERR} state_t;
  function automatic logic is_legal_op(input logic [4:0] op);
    return op inside {OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_INC, OP_DEC, OP_AND, OP_OR, OP_XOR,
                      OP_NOT, OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_SLT, OP_SLE, OP_SGT, OP_SGE,
                      OP_SEQ, OP_SNE};
  endfunction
  function automatic logic is_arith_op(input logic [4:0] op);
    return op[4:3] == 2'b00;
  endfunction
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 8x16 register file, two combinational reads, one load/writeback write port
module alu_regfile
  import alu_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  state_t            state,
  input  logic              ld_valid,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);
  logic [DATA_W-1:0] regs_q [2**REG_AW];
  logic [DATA_W-1:0] regs_d [2**REG_AW];
  // direct loads land only while idle; ALU results land in writeback
  always_comb begin
    regs_d = regs_q;
    if (state == ST_IDLE && ld_valid) regs_d[ld_addr] = ld_data;
    else if (state == ST_WB) regs_d[wb_addr] = wb_data;
  end
  // storage, cleared asynchronously
  always_ff @(posedge clk or posedge rst)
    if (rst) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  assign rd_a = regs_q[ra];
  assign rd_b = regs_q[rb];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues instructions to a combinational ALU and writes results back
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] instr,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_code,
  output logic              alu_coe,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_vout,
  input  logic              alu_cout,
  output logic              res_valid,
  output logic [REG_AW-1:0] res_rd,
  output logic [DATA_W-1:0] res_data,
  output logic              vflag,
  output logic              cflag,
  output logic              err_illegal
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_data_q, res_data_d, rs_val, rt_val;
  logic [4:0]        alu_code_q, alu_code_d, op;
  logic [REG_AW-1:0] rd_q, rd_d, res_rd_q, res_rd_d;
  logic              alu_coe_q, alu_coe_d, vflag_q, vflag_d, cflag_q, cflag_d;
  logic              res_valid_q, res_valid_d, err_q, err_d, accept, unused_rsvd;
  assign op          = instr[OP_HI:OP_LO];
  assign unused_rsvd = instr[0];
  assign instr_ready = state_q == ST_IDLE && !ld_valid;
  assign ld_ready    = state_q == ST_IDLE;
  assign accept      = instr_valid && instr_ready;
  alu_regfile u_rf (
    .clk      (clk),
    .rst      (rst),
    .state    (state_q),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .wb_addr  (rd_q),
    .wb_data  (alu_c),
    .ra       (instr[RS_HI:RS_LO]),
    .rb       (instr[RT_HI:RT_LO]),
    .rd_a     (rs_val),
    .rd_b     (rt_val)
  );
  // next state, operand latching at acceptance, writeback pulses and flag update
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_code_d  = alu_code_q;
    alu_coe_d   = alu_coe_q;
    rd_d        = rd_q;
    vflag_d     = vflag_q;
    cflag_d     = cflag_q;
    res_valid_d = state_q == ST_WB;
    err_d       = state_q == ST_ERR;
    res_rd_d    = res_valid_d ? rd_q : res_rd_q;
    res_data_d  = res_valid_d ? alu_c : res_data_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d = is_legal_op(op) ? ST_EXEC : ST_ERR;
        if (is_legal_op(op)) begin
          alu_a_d    = rs_val;
          alu_b_d    = rt_val;
          alu_code_d = op;
          alu_coe_d  = instr[COE_BIT];
          rd_d       = instr[RD_HI:RD_LO];
        end
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        state_d = ST_IDLE;
        vflag_d = is_arith_op(alu_code_q) ? alu_vout : vflag_q;
        cflag_d = is_arith_op(alu_code_q) ? alu_cout : cflag_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // control and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_code_q  <= '0;
      alu_coe_q   <= 1'b1;
      rd_q        <= '0;
      vflag_q     <= 1'b0;
      cflag_q     <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      res_rd_q    <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_code_q  <= alu_code_d;
      alu_coe_q   <= alu_coe_d;
      rd_q        <= rd_d;
      vflag_q     <= vflag_d;
      cflag_q     <= cflag_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      res_rd_q    <= res_rd_d;
      res_data_q  <= res_data_d;
    end
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_code    = alu_code_q;
  assign alu_coe     = alu_coe_q;
  assign res_valid   = res_valid_q;
  assign res_rd      = res_rd_q;
  assign res_data    = res_data_q;
  assign vflag       = vflag_q;
  assign cflag       = cflag_q;
  assign err_illegal = err_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized self-checking bench with a register-array reference model
module tb_alu_issue_ctrl;
  logic clk = 0, rst = 1;
  logic instr_valid = 0, ld_valid = 0;
  logic [15:0] instr = '0, ld_data = '0;
  logic [2:0] ld_addr = '0;
  logic instr_ready, ld_ready, alu_coe, alu_vout, alu_cout, res_valid, vflag, cflag, err_illegal;
  logic [15:0] alu_a, alu_b, alu_c, res_data;
  logic [4:0] alu_code;
  logic [2:0] res_rd;
  int errors = 0, checks = 0;
  logic [15:0] m_regs [8];
  logic m_v = 0, m_c = 0;
  logic [4:0] last_code = '0;
  logic [15:0] last_a = '0;
  logic [31:0] legal_mask = 32'h3F0F173F;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code), .alu_coe(alu_coe),
    .alu_c(alu_c), .alu_vout(alu_vout), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data),
    .vflag(vflag), .cflag(cflag), .err_illegal(err_illegal)
  );

  // behavioural ALU: returns {cout, vout, c}; cout only when coe (active low) is asserted
  function automatic logic [17:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [4:0] op, input logic coe);
    logic [16:0] s;
    logic [15:0] c;
    logic v;
    s = '0;
    v = 0;
    case (op)
      5'd0: begin s = {1'b0, a} + {1'b0, b}; c = s[15:0]; v = (a[15] == b[15]) && (c[15] != a[15]); end
      5'd2: begin s = {1'b0, a} - {1'b0, b}; c = s[15:0]; v = (a[15] != b[15]) && (c[15] != a[15]); end
      5'd8:  c = a & b;
      5'd9:  c = a | b;
      5'd10: c = a ^ b;
      5'd12: c = ~a;
      5'd16: c = a << b[3:0];
      5'd17: c = a >> b[3:0];
      5'd28: c = {15'd0, a == b};
      5'd29: c = {15'd0, a != b};
      default: begin s = {1'b0, a} + {1'b0, ~b}; c = s[15:0]; end
    endcase
    return {!coe && s[16], v, c};
  endfunction

  assign {alu_cout, alu_vout, alu_c} = alu_fn(alu_a, alu_b, alu_code, alu_coe);

  function automatic logic [15:0] model_apply(input logic [15:0] ins);
    logic [17:0] r;
    r = alu_fn(m_regs[ins[7:5]], m_regs[ins[4:2]], ins[15:11], ins[1]);
    m_regs[ins[10:8]] = r[15:0];
    if (ins[15:14] == 2'b00) begin m_v = r[16]; m_c = r[17]; end
    return r[15:0];
  endfunction

  task automatic do_load(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_valid = 1; ld_addr = a; ld_data = d;
    #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready got=%b exp=1", ld_ready); end
    @(posedge clk); #1 ld_valid = 0;
    m_regs[a] = d;
  endtask

  // full issue of one instruction with cycle-exact checks against the model
  task automatic run_instr(input logic [15:0] ins);
    logic legal;
    logic [15:0] ea, eb, er;
    logic [4:0] op;
    op = ins[15:11];
    legal = legal_mask[op];
    ea = m_regs[ins[7:5]];
    eb = m_regs[ins[4:2]];
    @(negedge clk);
    instr = ins; instr_valid = 1;
    #1;
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL issue_ready got=%b exp=1 ins=%h", instr_ready, ins); end
    @(posedge clk); #1 instr_valid = 0;
    if (legal) begin last_code = op; last_a = ea; end
    @(negedge clk);
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got=%b exp=0 ins=%h", instr_ready, ins); end
    checks++; if (alu_code !== last_code) begin errors++; $display("FAIL alu_code got=%b exp=%b ins=%h", alu_code, last_code, ins); end
    checks++; if (alu_a !== last_a) begin errors++; $display("FAIL alu_a got=%h exp=%h ins=%h", alu_a, last_a, ins); end
    if (legal) begin
      checks++; if (alu_b !== eb || alu_coe !== ins[1]) begin errors++; $display("FAIL alu_b_coe got=%h/%b exp=%h/%b", alu_b, alu_coe, eb, ins[1]); end
    end
    @(negedge clk);
    checks++; if (err_illegal !== !legal) begin errors++; $display("FAIL err_pulse got=%b exp=%b ins=%h", err_illegal, !legal, ins); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL early_res got=%b exp=0 ins=%h", res_valid, ins); end
    if (!legal) begin
      checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL err_ready got=%b exp=1", instr_ready); end
      return;
    end
    @(negedge clk);
    er = model_apply(ins);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL res_valid got=%b exp=1 ins=%h", res_valid, ins); end
    checks++; if (res_data !== er || res_rd !== ins[10:8]) begin errors++; $display("FAIL res got=%h@%0d exp=%h@%0d ins=%h", res_data, res_rd, er, ins[10:8], ins); end
    checks++; if (vflag !== m_v || cflag !== m_c) begin errors++; $display("FAIL flags got=%b%b exp=%b%b ins=%h", vflag, cflag, m_v, m_c, ins); end
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL err_spurious got=%b exp=0", err_illegal); end
  endtask

  task automatic read_reg(input logic [2:0] i);
    run_instr({5'b01001, i, i, i, 2'b10});
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (alu_code !== 5'd0 || alu_coe !== 1'b1 || alu_a !== 16'h0 || alu_b !== 16'h0) begin
      errors++; $display("FAIL reset_alu got=%b/%b/%h/%h exp=00000/1/0000/0000", alu_code, alu_coe, alu_a, alu_b); end
    checks++; if (res_valid !== 0 || err_illegal !== 0 || vflag !== 0 || cflag !== 0 || res_data !== 0 || res_rd !== 0) begin
      errors++; $display("FAIL reset_out got=%b%b%b%b %h %0d exp=0000 0000 0", res_valid, err_illegal, vflag, cflag, res_data, res_rd); end
    rst = 0;
    #1;
    checks++; if (instr_ready !== 1'b1 || ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b%b exp=11", instr_ready, ld_ready); end
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    read_reg(3'd4);
  endtask

  task automatic test_add();
    do_load(3'd1, 16'h7FFF);
    do_load(3'd2, 16'h0001);
    run_instr(16'h0328);
    checks++; if (res_data !== 16'h8000 || vflag !== 1'b1 || res_rd !== 3'd3) begin
      errors++; $display("FAIL add_const got=%h v=%b rd=%0d exp=8000 v=1 rd=3", res_data, vflag, res_rd); end
    read_reg(3'd3);
  endtask

  task automatic test_logic();
    run_instr(16'h4328);
    checks++; if (res_data !== 16'h0001 || vflag !== 1'b1) begin
      errors++; $display("FAIL and_const got=%h v=%b exp=0001 v=1", res_data, vflag); end
  endtask

  task automatic test_illegal();
    run_instr(16'h3000);
    @(negedge clk);
    checks++; if (err_illegal !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL err_width got=%b res=%b exp=0 0", err_illegal, res_valid); end
    for (int i = 0; i < 4; i++) read_reg(i[2:0]);
  endtask

  task automatic test_back_to_back();
    logic [15:0] prog [3];
    logic [15:0] exp_q [$];
    int k = 0, last = -1;
    prog[0] = {5'd0, 3'd4, 3'd1, 3'd2, 2'b00};
    prog[1] = {5'd2, 3'd5, 3'd4, 3'd1, 2'b00};
    prog[2] = {5'd10, 3'd6, 3'd5, 3'd4, 2'b10};
    for (int cyc = 0; cyc < 30 && (k < 3 || exp_q.size() > 0); cyc++) begin
      @(negedge clk);
      instr_valid = (k < 3);
      if (k < 3) instr = prog[k];
      #1;
      if (res_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra got=%h exp=none", res_data); end
        else if (res_data !== exp_q[0]) begin errors++; $display("FAIL b2b_res got=%h exp=%h", res_data, exp_q[0]); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (instr_valid && instr_ready) begin
        if (last >= 0) begin
          checks++; if (cyc - last != 3) begin errors++; $display("FAIL b2b_spacing got=%0d exp=3", cyc - last); end
        end
        last = cyc;
        last_code = prog[k][15:11];
        last_a = m_regs[prog[k][7:5]];
        exp_q.push_back(model_apply(prog[k]));
        k++;
      end
    end
    instr_valid = 0;
    checks++; if (k != 3 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_timeout got=%0d/%0d exp=3/0", k, exp_q.size()); end
    checks++; if (vflag !== m_v || cflag !== m_c) begin errors++; $display("FAIL b2b_flags got=%b%b exp=%b%b", vflag, cflag, m_v, m_c); end
  endtask

  task automatic test_ld_priority();
    logic [15:0] ins, er;
    ins = {5'b01001, 3'd6, 3'd5, 3'd5, 2'b10};
    @(negedge clk);
    ld_valid = 1; ld_addr = 3'd5; ld_data = 16'h1234; instr_valid = 1; instr = ins;
    #1;
    checks++; if (instr_ready !== 1'b0 || ld_ready !== 1'b1) begin errors++; $display("FAIL prio_ready got=%b%b exp=01", instr_ready, ld_ready); end
    @(posedge clk); #1 ld_valid = 0;
    m_regs[5] = 16'h1234;
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL prio_accept got=%b exp=1", instr_ready); end
    @(posedge clk); #1 instr_valid = 0;
    last_code = 5'b01001; last_a = 16'h1234;
    er = model_apply(ins);
    @(negedge clk);
    checks++; if (alu_a !== 16'h1234) begin errors++; $display("FAIL prio_operand got=%h exp=1234", alu_a); end
    repeat (2) @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_data !== er || res_rd !== 3'd6) begin
      errors++; $display("FAIL prio_res got=%b %h@%0d exp=1 %h@6", res_valid, res_data, res_rd, er); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) do_load(3'($urandom_range(0, 7)), 16'($urandom));
      else run_instr(16'($urandom));
    end
  endtask

  task automatic test_reset_exec();
    do_load(3'd1, 16'h7FFF);
    do_load(3'd2, 16'h0001);
    run_instr(16'h0328);
    @(negedge clk);
    instr = 16'h0328; instr_valid = 1;
    @(posedge clk); #1 instr_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++; if (res_valid !== 0 || vflag !== 0 || cflag !== 0 || alu_coe !== 1 || instr_ready !== 1) begin
      errors++; $display("FAIL rst_exec got=%b%b%b%b%b exp=00011", res_valid, vflag, cflag, alu_coe, instr_ready); end
    rst = 0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_abandon got=%b exp=0", res_valid); end
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_v = 0; m_c = 0; last_code = '0; last_a = '0;
    for (int i = 0; i < 8; i++) read_reg(i[2:0]);
  endtask

  initial begin
    test_reset();
    test_add();
    test_logic();
    test_illegal();
    test_back_to_back();
    test_ld_priority();
    test_random();
    test_reset_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Instruction issue and writeback controller that acts as the initiator for the 16-bit combinational ALU. It accepts 16-bit ALU instructions over a valid/ready handshake and reads operands from an internal 8x16 register file. It drives alu_code, operands and coe to the ALU, then captures C, vout and cout the following cycle, writes the result back and maintains the V/C flag register.

Parameters:
DATA_W, 16, operand/result width; fixed to the ALU width.
REG_AW, 3, register-file address width (2**REG_AW registers).

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  reset; asynchronous and active-high
instr_valid  in  1  instruction offered
instr_ready  out  1  controller accepts the instruction this cycle
instr  in  16  [15:11] op, [10:8] rd, [7:5] rs, [4:2] rt, [1] coe (active-low carry-out enable), [0] reserved (ignored)
ld_valid  in  1  direct register load request
ld_ready  out  1  load accepted this cycle
ld_addr  in  3  load target register
ld_data  in  16  load value
alu_a  out  16  operand A to ALU (registered)
alu_b  out  16  operand B to ALU (registered)
alu_code  out  5  ALU operation code (registered)
alu_coe  out  1  ALU carry-out enable, active low (registered)
alu_c  in  16  ALU result
alu_vout  in  1  ALU overflow
alu_cout  in  1  ALU carry-out
res_valid  out  1  one-cycle pulse: result written back
res_rd  out  3  destination of the written result
res_data  out  16  written result
vflag  out  1  overflow flag register
cflag  out  1  carry flag register
err_illegal  out  1  one-cycle pulse: illegal opcode dropped

Behaviour:
- States: IDLE, EXEC, WB, ERR.
- Reset (asynchronous, any state): state IDLE. All 8 registers = 0x0000. alu_a/alu_b = 0x0000, alu_code = 5'b00000, alu_coe = 1. vflag = cflag = 0. res_valid = err_illegal = 0, res_rd = 0, res_data = 0x0000.
- Legal opcodes: 00000-00101, 01000, 01001, 01010, 01100, 10000-10011, 11000-11101. Every other code is illegal.
- instr_ready = (state==IDLE) && !ld_valid. ld_ready = (state==IDLE).
- Load has priority over instr in IDLE. When both valids are high in the same cycle, the load is written and the instr is not accepted. ld_valid outside IDLE is ignored (ld_ready=0).
- Accepting a legal instr in IDLE:
  - Latch alu_a = R[rs], alu_b = R[rt], alu_code = op, alu_coe = instr[1], rd.
  - Go to EXEC.
- EXEC (1 cycle): operands are stable at the ALU; the combinational ALU settles. Go to WB.
- WB (1 cycle), sampling the alu_* inputs:
  - R[rd] = alu_c. Pulse res_valid with res_rd = rd and res_data = alu_c.
  - If op[4:3]==2'b00: vflag = alu_vout, cflag = alu_cout. Otherwise the flags hold.
  - Go to IDLE.
- Accepting an illegal instr: go to ERR. In ERR, pulse err_illegal for 1 cycle; there is no register write and the flags and alu_* outputs hold. Go to IDLE.
- Latency: acceptance edge to register-file update is 2 cycles (EXEC, WB); throughput is 1 instruction per 3 cycles. A back-to-back instruction sees the previous result; no hazard logic is needed.
- rd == rs or rd == rt: operands are latched at acceptance, so the write in WB is safe.
- The alu_* outputs hold their last values in IDLE; they are never driven combinationally from instr.
- Reset asserted in EXEC or WB: the pending write is abandoned, with no res_valid and no flag update.

Decomposition:
- Shared package: the ALU opcode constants (add..sne, 5-bit), instruction field bit positions, state encodings, and the is_legal_op and is_arith_op (op[4:3]==00) helpers.
- One sub-module, alu_regfile: 8x16 storage, two combinational read ports and one write port, with the load/WB write mux selected by state. Asynchronous reset clears all registers.

Test Plan:
- Load R1=0x7FFF and R2=0x0001, then issue instr 0x0328 (add r3,r1,r2). In EXEC: alu_code=00000, alu_a=0x7FFF, alu_b=0x0001, alu_coe=0. With the ALU model, WB gives res_valid, res_rd=3, res_data=0x8000, R3=0x8000, vflag=1.
- Then issue instr 0x4328 (and r3,r1,r2). Result is 0x0001 and vflag stays 1 (logic op; flags hold).
- Issue instr 0x3000 (op 00110, illegal). err_illegal pulses 1 cycle, 2 cycles after acceptance. There is no res_valid, all registers are unchanged, and instr_ready is high again the next cycle.
- Hold instr_valid continuously with 3 instructions queued. Each is accepted exactly every 3rd cycle, and instr_ready=0 in EXEC/WB.
- Assert ld_valid (R5=0x1234) and instr_valid in the same IDLE cycle. The load is written, the instr is accepted the following cycle, and it reads R5=0x1234 if rs=5.
- Assert rst during EXEC of an add. The next cycle shows state IDLE, every register at 0x0000, vflag=cflag=0, no res_valid, and alu_coe=1.
